// File: rtl/whirlpool_pkg.sv
// Whirlpool constants, state type and byte-slice helpers.
// Row 0 = bits [511:448]; byte 0 of a row is its MSB.
package whirlpool_pkg;

    localparam int ROWS  = 8;
    localparam int BYTES = 8;

    typedef enum logic {IDLE, ROUND} state_t;

    // First row of the theta circulant matrix
    localparam logic [63:0] THETA_C = 64'h0101040108050209;

    localparam logic [2047:0] SBOX = {
        128'h1823c6e887b8014f36a6d2f5796f9152,
        128'h60bc9b8ea30c7b351de0d7c22e4bfe57,
        128'h157737e59ff04ada58c9290ab1a06b85,
        128'hbd5d10f4cb3e0567e427418ba77d95d8,
        128'hfbee7c66dd17479eca2dbf07ad5a8333,
        128'h6302aa71c81949d9f2e35b889a2632b0,
        128'he90fd580becd3448ff7a905f20681aae,
        128'hb454932264f173124008c3ecdba18d3d,
        128'h9700cf2b7682d61bb5af6a5045f330ef,
        128'h3f55a2ea65ba2fc0de1cfd4d9275068a,
        128'hb2e60e1f62d4a896f9c525598472394c,
        128'h5e78388cd1a5e261b3219c1e43c7fc04,
        128'h51996d0dfadf7e243babce118f4eb7eb,
        128'h3c8194f7b9132cd3e76ec40356447fa9,
        128'h2abbc153dc0b9d6c3174f646ac8914e1,
        128'h163a690970b6d0edcc4298a4285cf886
    };

    function automatic logic [63:0] row_of(input logic [511:0] x, input int i);
        return x[64*(ROWS-1-i) +: 64];
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] r, input int j);
        return r[8*(BYTES-1-j) +: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        return SBOX[8*(255-int'(v)) +: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int b = 0; b < 8; b++) begin
            if (c[b]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // RC[r] row 0 is S-box bytes 8(r-1)..8r-1
    function automatic logic [63:0] rc(input logic [3:0] r);
        if (r == 4'd0 || r > 4'd10) return '0;
        return SBOX[64*(32-int'(r)) +: 64];
    endfunction

endpackage

// File: rtl/process_row.sv
// One Whirlpool row: bytewise S-box (gamma) then circulant mix (theta).
// Combinational, 64 bits in and out.
module process_row
    import whirlpool_pkg::*;
(
    input  logic [63:0] row_in,
    output logic [63:0] row_out
);

    logic [7:0] g [BYTES];
    logic [7:0] acc;

    always_comb begin
        for (int j = 0; j < BYTES; j++) begin
            g[j] = sbox(byte_of(row_in, j));
        end
    end

    always_comb begin
        row_out = '0;
        acc     = '0;
        for (int j = 0; j < BYTES; j++) begin
            acc = '0;
            for (int k = 0; k < BYTES; k++) begin
                acc = acc ^ gmul(g[k], byte_of(THETA_C, (j - k + BYTES) % BYTES));
            end
            row_out[8*(BYTES-1-j) +: 8] = acc;
        end
    end

endmodule

// File: rtl/whirlpool_rho.sv
// rho = pi routing followed by gamma+theta on each row.
// gamma is bytewise, so pi can be applied first as pure wiring.
module whirlpool_rho
    import whirlpool_pkg::*;
(
    input  logic [511:0] x,
    output logic [511:0] y
);

    logic [511:0] p;

    always_comb begin
        p = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < BYTES; j++) begin
                p[64*(ROWS-1-i) + 8*(BYTES-1-j) +: 8] =
                    byte_of(row_of(x, (i - j + ROWS) % ROWS), j);
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        process_row u_row (
            .row_in  (p[64*(ROWS-1-i) +: 64]),
            .row_out (y[64*(ROWS-1-i) +: 64])
        );
    end

endmodule

// File: rtl/whirlpool_compress_seq.sv
// Iterative Whirlpool compression: key schedule and cipher in lock-step,
// one round per clock, Miyaguchi-Preneel feed-forward on the last round.
module whirlpool_compress_seq
    import whirlpool_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] h_in,
    input  logic [511:0] m_in,
    output logic         ready,
    output logic         done,
    output logic [511:0] h_out
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    state_t       state;
    state_t       state_nx;
    logic [511:0] k;
    logic [511:0] s;
    logic [511:0] hs;
    logic [511:0] ms;
    logic [3:0]   rnd;
    logic [511:0] k_rho;
    logic [511:0] s_rho;
    logic [511:0] kn;
    logic [511:0] sn;
    logic         accept;
    logic         last;
    logic         busy;

    whirlpool_rho u_rho_k (.x(k), .y(k_rho));
    whirlpool_rho u_rho_s (.x(s), .y(s_rho));

    assign kn   = k_rho ^ {rc(rnd), 448'b0};
    assign sn   = s_rho ^ kn;
    assign last = (rnd == LAST_RND);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = ROUND;
            ROUND: if (last)  state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE);
        busy   = (state == ROUND);
        accept = ready & start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            s     <= '0;
            hs    <= '0;
            ms    <= '0;
            rnd   <= '0;
            h_out <= '0;
            done  <= 1'b0;
        end else begin
            done <= busy & last;
            if (accept) begin
                k   <= h_in;
                s   <= h_in ^ m_in;
                hs  <= h_in;
                ms  <= m_in;
                rnd <= 4'd1;
            end else if (busy) begin
                k <= kn;
                s <= sn;
                if (last) h_out <= sn ^ hs ^ ms;
                else      rnd   <= rnd + 4'd1;
            end
        end
    end

endmodule
